unpack_sp: RTL and testbench

UNPACK_SP -- requirements
Module: unpack_sp

---
 rtl/unpack_sp.sv | 167 ++++++++++++++++
 tb/tb_unpack_sp.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/unpack_sp.sv
// Unpacks 32-bit source words holding two 16-bit samples into one extended sample per destination word.
// Optional feature: define UNPACK_SP_SIGN_EXT_EN to sign-extend samples (zero-extension otherwise).
module unpack_sp #(
    parameter int unsigned N_WORDS  = 64,
    parameter int unsigned SRC_BASE = 0,
    parameter int unsigned DST_BASE = 0
) (
    input  logic        Clock_50,
    input  logic        Reset,
    input  logic        start,
    output logic [6:0]  DP_RAM_address_X,
    input  logic [31:0] DP_RAM_read_data_X,
    output logic [6:0]  DP_RAM_address,
    output logic [31:0] DP_RAM_write_data,
    output logic        DP_RAM_we,
    output logic        busy,
    output logic        finish
);

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SMPL_W = 16;
    localparam int unsigned CNT_W  = 7;

    localparam logic [ADDR_W-1:0] SRC_A = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] DST_A = ADDR_W'(DST_BASE);
    localparam logic [CNT_W:0]    N_CMP = (CNT_W + 1)'(N_WORDS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LEAD_IN  = 3'd1,
        WRITE_HI = 3'd2,
        WRITE_LO = 3'd3,
        DONE     = 3'd4
    } state_t;

    // Sample-to-word extension selected at build time.
    function automatic logic [DATA_W-1:0] ext(input logic [SMPL_W-1:0] s);
`ifdef UNPACK_SP_SIGN_EXT_EN
        ext = {{(DATA_W - SMPL_W){s[SMPL_W-1]}}, s};
`else
        ext = {{(DATA_W - SMPL_W){1'b0}}, s};
`endif
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    k_q, k_d;
    logic                lead_q, lead_d;
    logic [SMPL_W-1:0]   lo_q, lo_d;
    logic [ADDR_W-1:0]   addr_x_q, addr_x_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                finish_q, finish_d;

    logic                enter_hi;
    logic [CNT_W-1:0]    k_nxt;

    // State and output registers; synchronous reset clears everything.
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state_q  <= IDLE;
            k_q      <= '0;
            lead_q   <= 1'b0;
            lo_q     <= '0;
            addr_x_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            lead_q   <= lead_d;
            lo_q     <= lo_d;
            addr_x_q <= addr_x_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        lead_d   = lead_q;
        lo_d     = lo_q;
        addr_x_d = addr_x_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        busy_d   = busy_q;
        finish_d = 1'b0;
        enter_hi = 1'b0;
        k_nxt    = k_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d  = LEAD_IN;
                    addr_x_d = SRC_A;
                    busy_d   = 1'b1;
                    lead_d   = 1'b0;
                    k_d      = '0;
                end
            end
            LEAD_IN: begin
                if (!lead_q) begin
                    lead_d = 1'b1;
                end else begin
                    enter_hi = 1'b1;
                    k_nxt    = '0;
                end
            end
            WRITE_HI: begin
                state_d = WRITE_LO;
                addr_d  = addr_q + ADDR_W'(1);
                wdata_d = ext(lo_q);
                we_d    = 1'b1;
            end
            WRITE_LO: begin
                if (({1'b0, k_q} + (CNT_W + 1)'(1)) < N_CMP) begin
                    enter_hi = 1'b1;
                    k_nxt    = k_q + CNT_W'(1);
                end else begin
                    state_d  = DONE;
                    finish_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                lead_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The high sample is written straight from the read port; only the low half needs holding.
        if (enter_hi) begin
            state_d = WRITE_HI;
            k_d     = k_nxt;
            lo_d    = DP_RAM_read_data_X[SMPL_W-1:0];
            addr_d  = DST_A + {k_nxt[CNT_W-2:0], 1'b0};
            wdata_d = ext(DP_RAM_read_data_X[DATA_W-1:SMPL_W]);
            we_d    = 1'b1;
            if (({1'b0, k_nxt} + (CNT_W + 1)'(2)) <= N_CMP) begin
                addr_x_d = SRC_A + k_nxt + ADDR_W'(1);
            end
        end
    end

    assign DP_RAM_address_X  = addr_x_q;
    assign DP_RAM_address    = addr_q;
    assign DP_RAM_write_data = wdata_q;
    assign DP_RAM_we         = we_q;
    assign busy              = busy_q;
    assign finish            = finish_q;

endmodule

// File: tb/tb_unpack_sp.sv
// Scoreboard bench for unpack_sp: default instance (64 words) and a 1-word instance at offset bases.
module tb_unpack_sp;

    logic        clk;
    logic        rst;
    logic        start0, start1;
    logic [6:0]  ax0, ax1, a0, a1;
    logic [31:0] rd0, rd1, w0, w1;
    logic        we0, we1, busy0, busy1, fin0, fin1;

    logic [31:0] mem0 [128];
    logic [31:0] mem1 [128];

    typedef struct {int cyc; int addr; logic [31:0] data;} wr_t;
    typedef struct {int cyc; int dut; bit zero; bit busy;} snap_t;

    wr_t   q0[$];
    wr_t   q1[$];
    int    f0[$];
    int    f1[$];
    snap_t snaps[$];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    bit end_req = 1'b0;
    bit end_done = 1'b0;

`ifdef UNPACK_SP_SIGN_EXT_EN
    localparam logic [31:0] EXP_8001 = 32'hFFFF8001;
    localparam logic [31:0] EXP_ABCD = 32'hFFFFABCD;
`else
    localparam logic [31:0] EXP_8001 = 32'h00008001;
    localparam logic [31:0] EXP_ABCD = 32'h0000ABCD;
`endif

    unpack_sp dut0 (
        .Clock_50(clk), .Reset(rst), .start(start0),
        .DP_RAM_address_X(ax0), .DP_RAM_read_data_X(rd0),
        .DP_RAM_address(a0), .DP_RAM_write_data(w0), .DP_RAM_we(we0),
        .busy(busy0), .finish(fin0)
    );

    unpack_sp #(.N_WORDS(1), .SRC_BASE(5), .DST_BASE(10)) dut1 (
        .Clock_50(clk), .Reset(rst), .start(start1),
        .DP_RAM_address_X(ax1), .DP_RAM_read_data_X(rd1),
        .DP_RAM_address(a1), .DP_RAM_write_data(w1), .DP_RAM_we(we1),
        .busy(busy1), .finish(fin1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Source RAMs: one register stage after the DUT's registered address.
    always @(posedge clk) begin
        rd0 <= mem0[ax0];
        rd1 <= mem1[ax1];
    end

    task automatic chk_write(input int d, input logic [6:0] a, input logic [31:0] w);
        wr_t e;
        bit  have;
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        vectors++;
        if (!have) begin
            miscompares++;
            $display("FAIL dut%0d_unexpected_write cyc=%0d got addr=%0d data=%h required no write", d, cyc, a, w);
        end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if (e.cyc != cyc || e.addr != int'(a) || e.data != w) begin
                miscompares++;
                $display("FAIL dut%0d_write got cyc=%0d addr=%0d data=%h required cyc=%0d addr=%0d data=%h",
                         d, cyc, a, w, e.cyc, e.addr, e.data);
            end
        end
    endtask

    task automatic chk_fin(input int d);
        int  e;
        bit  have;
        have = (d == 0) ? (f0.size() > 0) : (f1.size() > 0);
        vectors++;
        if (!have) begin
            miscompares++;
            $display("FAIL dut%0d_unexpected_finish cyc=%0d required no finish", d, cyc);
        end else begin
            if (d == 0) e = f0.pop_front();
            else        e = f1.pop_front();
            if (e != cyc) begin
                miscompares++;
                $display("FAIL dut%0d_finish_cycle got %0d required %0d", d, cyc, e);
            end
        end
    endtask

    task automatic chk_snap(input snap_t s);
        logic [6:0]  x, a;
        logic [31:0] w;
        logic        we, b, f;
        if (s.dut == 0) begin x = ax0; a = a0; w = w0; we = we0; b = busy0; f = fin0; end
        else            begin x = ax1; a = a1; w = w1; we = we1; b = busy1; f = fin1; end
        vectors++;
        if (s.zero) begin
            if (x != 0 || a != 0 || w != 0 || we || b || f) begin
                miscompares++;
                $display("FAIL dut%0d_reset_state cyc=%0d got ax=%0d a=%0d w=%h we=%b busy=%b fin=%b required all 0",
                         s.dut, cyc, x, a, w, we, b, f);
            end
        end else if (b != s.busy) begin
            miscompares++;
            $display("FAIL dut%0d_busy cyc=%0d got %b required %b", s.dut, cyc, b, s.busy);
        end
    endtask

    task automatic chk_empty(input string name, input int n);
        vectors++;
        if (n != 0) begin
            miscompares++;
            $display("FAIL %s leftover got %0d required 0", name, n);
        end
    endtask

    // Monitor: pops expectations whenever a DUT presents a write or finish.
    always @(negedge clk) begin
        if (we0) chk_write(0, a0, w0);
        if (we1) chk_write(1, a1, w1);
        if (fin0) chk_fin(0);
        if (fin1) chk_fin(1);
        for (int i = snaps.size() - 1; i >= 0; i--) begin
            if (snaps[i].cyc == cyc) begin
                chk_snap(snaps[i]);
                snaps.delete(i);
            end
        end
        if (busy1) begin
            vectors++;
            if (ax1 != 7'd5) begin
                miscompares++;
                $display("FAIL dut1_read_addr cyc=%0d got %0d required 5", cyc, ax1);
            end
        end
        if (end_req && !end_done) begin
            chk_empty("dut0_writes", q0.size());
            chk_empty("dut1_writes", q1.size());
            chk_empty("dut0_finish", f0.size());
            chk_empty("dut1_finish", f1.size());
            chk_empty("snapshots", snaps.size());
            end_done = 1'b1;
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_snap(input int c, input int d, input bit z, input bit b);
        snap_t s;
        s.cyc = c; s.dut = d; s.zero = z; s.busy = b;
        snaps.push_back(s);
    endtask

    // Full 64-word run on dut0; dst[j] = j for the counting pattern.
    task automatic push_run0(input int c0, input bit special, input bit idle_after);
        wr_t e;
        for (int j = 0; j < 128; j++) begin
            e.cyc = c0 + 2 + j;
            e.addr = j;
            e.data = 32'(j);
            if (special && j == 0) e.data = EXP_8001;
            if (special && j == 1) e.data = 32'h00007FFF;
            q0.push_back(e);
        end
        f0.push_back(c0 + 130);
        push_snap(c0, 0, 1'b0, 1'b1);
        push_snap(c0 + 130, 0, 1'b0, 1'b1);
        if (idle_after) push_snap(c0 + 131, 0, 1'b0, 1'b0);
    endtask

    initial begin
        int  c0, c1;
        wr_t e;
        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        for (int i = 0; i < 128; i++) begin
            mem0[i] = {16'(2 * i), 16'(2 * i + 1)};
            mem1[i] = 32'hDEAD_0000 | 32'(i);
        end
        mem1[5] = 32'h1234_ABCD;

        repeat (3) @(negedge clk);
        push_snap(cyc + 1, 0, 1'b1, 1'b0);
        push_snap(cyc + 1, 1, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Counting pattern on dut0 with stray starts; single-word run on dut1.
        start0 = 1'b1;
        start1 = 1'b1;
        c0 = cyc + 1;
        push_run0(c0, 1'b0, 1'b1);
        e.cyc = c0 + 2; e.addr = 10; e.data = 32'h0000_1234; q1.push_back(e);
        e.cyc = c0 + 3; e.addr = 11; e.data = EXP_ABCD;      q1.push_back(e);
        f1.push_back(c0 + 4);
        push_snap(c0, 1, 1'b0, 1'b1);
        push_snap(c0 + 4, 1, 1'b0, 1'b1);
        push_snap(c0 + 5, 1, 1'b0, 1'b0);
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        wait_cyc(c0 + 9);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_cyc(c0 + 59);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_cyc(c0 + 136);

        // Extension boundary: 0x8001 / 0x7FFF in word 0.
        mem0[0] = 32'h8001_7FFF;
        start0 = 1'b1;
        c0 = cyc + 1;
        push_run0(c0, 1'b1, 1'b1);
        @(negedge clk);
        start0 = 1'b0;
        wait_cyc(c0 + 136);
        mem0[0] = {16'd0, 16'd1};

        // Mid-run reset at E40, held through E41 together with start.
        start0 = 1'b1;
        c0 = cyc + 1;
        for (int j = 0; j < 38; j++) begin
            e.cyc = c0 + 2 + j; e.addr = j; e.data = 32'(j);
            q0.push_back(e);
        end
        push_snap(c0, 0, 1'b0, 1'b1);
        @(negedge clk);
        start0 = 1'b0;
        wait_cyc(c0 + 39);
        rst = 1'b1;
        push_snap(c0 + 40, 0, 1'b1, 1'b0);
        push_snap(c0 + 40, 1, 1'b1, 1'b0);
        push_snap(c0 + 41, 0, 1'b1, 1'b0);
        push_snap(c0 + 42, 0, 1'b1, 1'b0);
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start0 = 1'b0;
        wait_cyc(c0 + 44);

        // start held high: back-to-back runs with one IDLE cycle between.
        start0 = 1'b1;
        c0 = cyc + 1;
        c1 = c0 + 132;
        push_run0(c0, 1'b0, 1'b1);
        push_run0(c1, 1'b0, 1'b0);
        wait_cyc(c1 + 5);
        start0 = 1'b0;
        push_snap(c1 + 131, 0, 1'b0, 1'b0);
        wait_cyc(c1 + 136);

        end_req = 1'b1;
        for (int i = 0; i < 10 && !end_done; i++) @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
